// File: rtl/inst_prefetch.sv
// ---------------------------------------------------------------------------
// inst_prefetch
//
// Instruction prefetch buffer that sits between the core's program counter
// and a single-ported instruction ROM. It streams sequential words from the
// ROM into a small FIFO ahead of the core. It presents the head word
// combinationally when the core's pc matches that word. It flushes and
// restarts the stream whenever the core jumps somewhere the buffer does not
// cover.
//
// Parameters
//   DEPTH     number of prefetch buffer entries (power of two, 2..16)
//   RST_ADDR  first address prefetched after reset
//
// Ports
//   clk           rising-edge clock for all state
//   rst           asynchronous active-high reset
//   pc_i          address the core is fetching (bits [1:0] ignored)
//   pc_valid_i    pc_i is meaningful this cycle
//   inst_ack_i    core consumes the presented instruction this cycle
//   inst_o        instruction for pc_i, NOP (32'h0000_0013) when not valid
//   inst_valid_o  inst_o holds the word at pc_i
//   mem_req_o     read request to the instruction ROM
//   mem_addr_o    word-aligned ROM read address, stable while requesting
//   mem_ack_i     ROM returns data for the current request this cycle
//   mem_rdata_i   ROM read data, valid with mem_ack_i
// ---------------------------------------------------------------------------
module inst_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    input  logic        inst_ack_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [31:0]   r_pfAddr;
    logic          r_memReq;
    logic [31:0]   r_memAddr;
    logic [31:0]   r_addrMem [DEPTH];
    logic [31:0]   r_dataMem [DEPTH];

    logic [31:0]   w_pcAligned;
    logic [31:0]   w_headAddr;
    logic [31:0]   w_headData;
    logic          w_hit;
    logic          w_pop;
    logic          w_flush;
    logic          w_push;
    logic [CW-1:0] w_countNext;
    logic [31:0]   w_pfNext;

    // The core may hand us a byte address; only the word part matters.
    assign w_pcAligned = pc_i & 32'hFFFF_FFFC;

    assign w_headAddr  = r_addrMem[r_rdPtr];
    assign w_headData  = r_dataMem[r_rdPtr];

    assign w_hit = pc_valid_i && (r_count != '0) && (w_headAddr == w_pcAligned);
    assign w_pop = w_hit && inst_ack_i;

    // A non-empty buffer with the wrong head is useless, so any miss flushes.
    // An empty buffer is still on the right track as long as the core asks
    // for the word the stream will deliver next (r_pfAddr), so that case
    // only flushes when pc differs from it.
    assign w_flush = pc_valid_i && !w_hit &&
                     ((r_count != '0) || (w_pcAligned != r_pfAddr));

    // Data returned while a flush is happening belongs to the old stream and
    // is never written. The full guard is defensive: REQ is only held while
    // there is room.
    assign w_push = (r_state == REQ) && mem_ack_i && !w_flush &&
                    ((r_count != FULL) || w_pop);

    assign w_countNext = r_count + {{(CW-1){1'b0}}, w_push}
                                 - {{(CW-1){1'b0}}, w_pop};

    // 32-bit wrap from 32'hFFFF_FFFC to 0 falls out of the natural overflow.
    assign w_pfNext = r_pfAddr + 32'd4;

    assign inst_valid_o = w_hit;
    assign inst_o       = w_hit ? w_headData : NOP;
    assign mem_req_o    = r_memReq;
    assign mem_addr_o   = r_memAddr;

    // Buffer storage. Entries are only meaningful below r_count, so they need
    // no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addrMem[r_wrPtr] <= r_memAddr;
            r_dataMem[r_wrPtr] <= mem_rdata_i;
        end
    end

    // FIFO bookkeeping plus the ROM request FSM. DROP keeps the old request
    // on the bus until the ROM answers it, so only one request is ever in
    // flight. The answer is thrown away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_pfAddr  <= RST_ADDR;
            r_memReq  <= 1'b0;
            r_memAddr <= RST_ADDR;
        end else begin
            if (w_flush) begin
                r_count  <= '0;
                r_wrPtr  <= '0;
                r_rdPtr  <= '0;
                r_pfAddr <= w_pcAligned;
            end else begin
                if (w_push) begin
                    r_wrPtr  <= r_wrPtr + 1'b1;
                    r_pfAddr <= w_pfNext;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + 1'b1;
                end
                r_count <= w_countNext;
            end

            case (r_state)
                IDLE: begin
                    if (!w_flush && (r_count < FULL)) begin
                        r_state   <= REQ;
                        r_memReq  <= 1'b1;
                        r_memAddr <= r_pfAddr;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        if (w_push && (w_countNext < FULL)) begin
                            r_memAddr <= w_pfNext;
                        end else begin
                            r_state  <= IDLE;
                            r_memReq <= 1'b0;
                        end
                    end else if (w_flush) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (mem_ack_i) begin
                        r_state  <= IDLE;
                        r_memReq <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_memReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch
//
// Directed bench for inst_prefetch. One instance uses the default reset
// address and covers streaming, back-pressure, jumps, dropped requests and
// jump-with-ack. A second instance starts at 32'hFFFF_FFF8 and covers
// address wrap and reset during an outstanding request. Each instance has a
// small ROM responder that acks a configurable number of cycles after the
// request rises.
// ---------------------------------------------------------------------------
module tb_inst_prefetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pcValid;
    logic        instAck;
    logic [31:0] instData;
    logic        instValid;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;

    logic        rstW;
    logic [31:0] pcW;
    logic        pcValidW;
    logic        instAckW;
    logic [31:0] instDataW;
    logic        instValidW;
    logic        memReqW;
    logic [31:0] memAddrW;
    logic        memAckW;
    logic [31:0] memRdataW;

    int          checkCount = 0;
    int          passCount  = 0;
    int          romLat     = 1;
    logic        forceW     = 1'b0;

    inst_prefetch #(.DEPTH(4), .RST_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc),
        .pc_valid_i   (pcValid),
        .inst_ack_i   (instAck),
        .inst_o       (instData),
        .inst_valid_o (instValid),
        .mem_req_o    (memReq),
        .mem_addr_o   (memAddr),
        .mem_ack_i    (memAck),
        .mem_rdata_i  (memRdata)
    );

    inst_prefetch #(.DEPTH(4), .RST_ADDR(32'hFFFF_FFF8)) dutW (
        .clk          (clk),
        .rst          (rstW),
        .pc_i         (pcW),
        .pc_valid_i   (pcValidW),
        .inst_ack_i   (instAckW),
        .inst_o       (instDataW),
        .inst_valid_o (instValidW),
        .mem_req_o    (memReqW),
        .mem_addr_o   (memAddrW),
        .mem_ack_i    (memAckW),
        .mem_rdata_i  (memRdataW)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents: every word differs from its neighbours and from NOP.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    // ROM responder for the main instance: ack once the request has been
    // high for romLat cycles.
    initial begin
        int waitCnt;
        waitCnt  = 0;
        memAck   = 1'b0;
        memRdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (memReq && (waitCnt >= romLat)) begin
                memAck   = 1'b1;
                memRdata = romWord(memAddr);
                waitCnt  = 0;
            end else begin
                memAck   = 1'b0;
                memRdata = 32'hDEAD_BEEF;
                if (memReq) waitCnt = waitCnt + 1;
                else        waitCnt = 0;
            end
        end
    end

    // ROM responder for the wrap instance, fixed one-cycle latency, with a
    // force input to drive stray acks.
    initial begin
        int waitCnt;
        waitCnt   = 0;
        memAckW   = 1'b0;
        memRdataW = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (forceW || (memReqW && (waitCnt >= 1))) begin
                memAckW   = 1'b1;
                memRdataW = romWord(memAddrW);
                waitCnt   = 0;
            end else begin
                memAckW   = 1'b0;
                memRdataW = 32'hDEAD_BEEF;
                if (memReqW) waitCnt = waitCnt + 1;
                else         waitCnt = 0;
            end
        end
    end

    // Safety net in case the run stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts, and reports tag / observed / expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the main instance to present a valid instruction.
    task automatic waitValid();
        for (int k = 0; k < 40; k++) begin
            if (instValid) break;
            @(negedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for the main instance to raise its ROM request.
    task automatic waitReq();
        for (int k = 0; k < 40; k++) begin
            if (memReq) break;
            @(negedge clk);
            #1;
        end
    endtask

    // Present pc=a on the next falling edge, then check the word at a.
    task automatic applyStimulus(input string tag, input logic [31:0] a);
        @(negedge clk);
        pc = a;
        #1;
        waitValid();
        checkOutput(tag, instData, romWord(a));
    endtask

    initial begin
        logic        seen;
        int          n;
        logic [31:0] wAddrs [3];

        rst      = 1'b1;
        pc       = 32'h0;
        pcValid  = 1'b0;
        instAck  = 1'b0;
        rstW     = 1'b1;
        pcW      = 32'h0;
        pcValidW = 1'b0;
        instAckW = 1'b0;

        // Reset values.
        @(negedge clk);
        #1;
        checkOutput("rstReq",   32'(memReq),    32'd0);
        checkOutput("rstAddr",  memAddr,        32'h0000_0000);
        checkOutput("rstValid", 32'(instValid), 32'd0);
        checkOutput("rstInst",  instData,       NOP);
        checkOutput("rstAddrW", memAddrW,       32'hFFFF_FFF8);

        // First request goes out on the first edge after reset falls.
        @(negedge clk);
        rst     = 1'b0;
        pc      = 32'h0;
        pcValid = 1'b1;
        instAck = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("firstReq",  32'(memReq), 32'd1);
        checkOutput("firstAddr", memAddr,     32'h0000_0000);

        // Core stalls: buffer fills to DEPTH and requests stop.
        repeat (14) @(negedge clk);
        #1;
        checkOutput("fullReqOff",  32'(memReq),    32'd0);
        checkOutput("fullValid",   32'(instValid), 32'd1);
        checkOutput("fullHead0",   instData,       romWord(32'h0));

        // Core consumes 0x4..0xC in order.
        instAck = 1'b1;
        applyStimulus("seq04", 32'h04);
        applyStimulus("seq08", 32'h08);
        applyStimulus("seq0C", 32'h0C);

        // Stall again with 0x10..0x1C buffered.
        @(negedge clk);
        instAck = 1'b0;
        pc      = 32'h10;
        repeat (14) @(negedge clk);
        #1;
        checkOutput("full2Valid", 32'(instValid), 32'd1);
        checkOutput("full2Head",  instData,       romWord(32'h10));
        checkOutput("full2Req",   32'(memReq),    32'd0);

        // Jump to 0x100 with a full buffer.
        @(negedge clk);
        pc      = 32'h100;
        instAck = 1'b1;
        #1;
        checkOutput("jumpInvalid", 32'(instValid), 32'd0);
        checkOutput("jumpNop",     instData,       NOP);
        waitReq();
        checkOutput("jumpReqAddr", memAddr, 32'h100);
        waitValid();
        checkOutput("jump100", instData, romWord(32'h100));
        applyStimulus("jump104", 32'h104);
        applyStimulus("jump108", 32'h108);
        applyStimulus("jump10C", 32'h10C);

        // Jump while a slow request is outstanding: its data must be dropped.
        @(negedge clk);
        romLat = 3;
        pc     = 32'h20;
        #1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (memReq && (memAddr == 32'h20)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput("dropSeen20", 32'(seen), 32'd1);
        pc = 32'h100;
        @(negedge clk);
        #1;
        checkOutput("dropReqHeld",  32'(memReq), 32'd1);
        checkOutput("dropAddrHeld", memAddr,     32'h20);
        for (int k = 0; k < 20; k++) begin
            if (!memReq) break;
            @(negedge clk);
            #1;
        end
        pc = 32'h20;
        #1;
        checkOutput("dropNoPush", 32'(instValid), 32'd0);
        pc = 32'h100;
        #1;
        waitReq();
        checkOutput("dropNextAddr", memAddr, 32'h100);
        waitValid();
        checkOutput("dropData100", instData, romWord(32'h100));

        // Jump in the same cycle as an ack: that ack's data must be dropped.
        @(negedge clk);
        romLat = 1;
        pc     = 32'h40;
        #1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (memAck && (memAddr == 32'h40)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput("ackJumpSeen", 32'(seen), 32'd1);
        pc = 32'h200;
        @(negedge clk);
        #1;
        checkOutput("ackJumpIdle", 32'(memReq), 32'd0);
        pc = 32'h40;
        #1;
        checkOutput("ackJumpNoPush", 32'(instValid), 32'd0);
        pc = 32'h203;
        #1;
        waitReq();
        checkOutput("ackJumpAddr", memAddr, 32'h200);
        waitValid();
        checkOutput("ackJumpData", instData, romWord(32'h200));

        // pc_valid low: no flush, no pop, prefetch keeps going.
        @(negedge clk);
        pcValid = 1'b0;
        pc      = 32'h999;
        repeat (12) @(negedge clk);
        #1;
        checkOutput("noPcValid", 32'(instValid), 32'd0);
        checkOutput("noPcFull",  32'(memReq),    32'd0);
        pcValid = 1'b1;
        pc      = 32'h204;
        #1;
        checkOutput("noPcHit",  32'(instValid), 32'd1);
        checkOutput("noPcData", instData,       romWord(32'h204));

        // Wrap instance: address sequence across 32'hFFFF_FFFC.
        wAddrs[0] = 32'h1111_1111;
        wAddrs[1] = 32'h1111_1111;
        wAddrs[2] = 32'h1111_1111;
        n = 0;
        @(negedge clk);
        rstW = 1'b0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            #1;
            if (memAckW) begin
                wAddrs[n] = memAddrW;
                n++;
            end
        end
        checkOutput("wrapAddr0", wAddrs[0], 32'hFFFF_FFF8);
        checkOutput("wrapAddr1", wAddrs[1], 32'hFFFF_FFFC);
        checkOutput("wrapAddr2", wAddrs[2], 32'h0000_0000);

        // Reset during the following request drops it at once.
        @(negedge clk);
        #1;
        checkOutput("wrapReqBefore", 32'(memReqW), 32'd1);
        rstW = 1'b1;
        #1;
        checkOutput("wrapRstReq",  32'(memReqW), 32'd0);
        checkOutput("wrapRstAddr", memAddrW,     32'hFFFF_FFF8);

        // A stray ack while IDLE right after reset is ignored.
        forceW = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstW = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("wrapRelReq",  32'(memReqW), 32'd1);
        checkOutput("wrapRelAddr", memAddrW,     32'hFFFF_FFF8);
        forceW   = 1'b0;
        pcW      = 32'hFFFF_FFF8;
        pcValidW = 1'b1;
        #1;
        checkOutput("wrapStrayAck", 32'(instValidW), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
